aes_xif_scheduler: RTL
======================

AES_XIF_SCHEDULER -- requirements
Module: aes_xif_scheduler

Interface
REQ-001 Parameter X_ID_WIDTH, default 4, width of the X-interface instruction id.
REQ-002 Parameter DEPTH, default 2, number of pending-instruction entries; the value SHALL be a power of 2 and at least 2.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 issue_valid_i  in  1  issue request valid.
REQ-006 issue_ready_o  out  1  scheduler can accept an issue.
REQ-007 issue_id_i  in  X_ID_WIDTH  instruction id.
REQ-008 issue_op_i  in  2  operation: 00 aes32dsi, 01 aes32dsmi, 10 aes32esi, 11 aes32esmi.
REQ-009 issue_bs_i  in  2  byte select.
REQ-010 issue_rd_i  in  5  destination register index.
REQ-011 issue_rs1_i, issue_rs2_i  in  32 each  source operands.
REQ-012 commit_valid_i  in  1  commit event valid.
REQ-013 commit_id_i  in  X_ID_WIDTH  committed or killed id.
REQ-014 commit_kill_i  in  1  1 = kill, 0 = commit.
REQ-015 dp_op_o, dp_bs_o  out  2 each  operation and byte select to the shared combinational aes32 datapath.
REQ-016 dp_rs1_o, dp_rs2_o  out  32 each  operands to the datapath.
REQ-017 dp_rd_i  in  32  datapath result, combinational from the dp_* outputs.
REQ-018 result_valid_o  out  1  result valid.
REQ-019 result_ready_i  in  1  result accepted.
REQ-020 result_id_o, result_rd_o, result_data_o  out  X_ID_WIDTH / 5 / 32  result id, destination and data.
REQ-021 occupancy_o  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-022 Pending instructions SHALL be held in an in-order FIFO of DEPTH entries. Each entry holds id, op, bs, rd, rs1, rs2, a committed flag and a killed flag.
REQ-023 issue_ready_o SHALL equal (occupancy_o < DEPTH). It SHALL depend only on registered state and SHALL be low when full, even in a cycle in which an entry pops.
REQ-024 An issue handshake (issue_valid_i & issue_ready_o) SHALL write a new entry at the tail with both flags clear; the entry becomes visible in the next cycle.
REQ-025 Commit matching:
- A commit_valid_i event SHALL set the committed flag, plus the killed flag when commit_kill_i=1, on the oldest valid entry whose id matches and whose committed flag is clear.
- The entry SHALL be matched from the state at the start of the cycle; an entry written in the same cycle SHALL NOT match.
- An event with no match SHALL be ignored.
REQ-026 dp_op_o, dp_bs_o, dp_rs1_o and dp_rs2_o SHALL always present the head entry's fields, or zero when the FIFO is empty.
REQ-027 Head pop rules:
- A committed, killed head SHALL pop in one cycle and produce no result.
- A committed, non-killed head SHALL pop when the result register is empty or is being consumed (result_valid_o & result_ready_i). On pop, {id, rd, dp_rd_i} SHALL be captured into the result register.
- At most one pop SHALL occur per cycle.
REQ-028 result_valid_o SHALL rise the cycle after a non-killed pop. It SHALL stay high, with id/rd/data stable, until result_ready_i is sampled high. A back-to-back pop in the consuming cycle SHALL keep it high with the new contents.
REQ-029 Minimum latency SHALL be: issue at cycle T, commit at T+1, pop at T+2, result_valid_o at T+3.
REQ-030 A simultaneous issue and pop SHALL leave occupancy unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-031 Results SHALL be delivered in issue order; a later committed entry SHALL NOT bypass an uncommitted head.

Reset
REQ-032 While rst_i=1 at a clock edge, the block SHALL clear all entries, flags and pointers, whether idle or mid-operation.
REQ-033 After such an edge, the outputs SHALL be: occupancy_o=0, issue_ready_o=1, result_valid_o=0, and result_id_o, result_rd_o, result_data_o and all dp_* outputs = 0.
REQ-034 Commits and result_ready_i SHALL be ignored while rst_i=1.

Verification
Bench datapath stub: dp_rd_i = dp_rs1_o ^ dp_rs2_o.
REQ-035 Single instruction: issue id=3, op=10, rd=5, rs1=32'h0000_00FF, rs2=32'h0000_0F00 at T; commit id=3 at T+1; result_ready_i=1 -> result_valid_o high at T+3 only, with id=3, rd=5, data=32'h0000_0FFF.
REQ-036 Full: issue ids 1 and 2 with no commit -> issue_ready_o=0 and occupancy_o=2; a third issue_valid_i is not accepted.
REQ-037 Kill: issue id 1 and id 2; kill id 1, then commit id 2 -> exactly one result, with id=2; occupancy_o reaches 0.
REQ-038 Backpressure: two committed entries with result_ready_i=0 for 5 cycles -> first result held stable with occupancy_o=1; ready=1 for 2 cycles -> id order 1 then 2 back-to-back.
REQ-039 Out-of-order commit: commit id 2 before id 1 -> no result until id 1 is committed, then results in order 1, 2.
REQ-040 Reset mid-operation: assert rst_i one cycle while result_valid_o=1 and occupancy_o=1 -> next cycle result_valid_o=0, occupancy_o=0, issue_ready_o=1.

Source files
------------

// File: rtl/aes_xif_scheduler_if.sv
// X-interface bundle between the core and the aes32 scheduler,
// including the hooks to the shared combinational aes32 datapath.
interface aes_xif_scheduler_if #(
    parameter int X_ID_WIDTH = 4,
    parameter int DEPTH      = 2
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic [X_ID_WIDTH-1:0] issue_id_i;
    logic [1:0]            issue_op_i;
    logic [1:0]            issue_bs_i;
    logic [4:0]            issue_rd_i;
    logic [31:0]           issue_rs1_i;
    logic [31:0]           issue_rs2_i;

    logic                  commit_valid_i;
    logic [X_ID_WIDTH-1:0] commit_id_i;
    logic                  commit_kill_i;

    logic [1:0]            dp_op_o;
    logic [1:0]            dp_bs_o;
    logic [31:0]           dp_rs1_o;
    logic [31:0]           dp_rs2_o;
    logic [31:0]           dp_rd_i;

    logic                  result_valid_o;
    logic                  result_ready_i;
    logic [X_ID_WIDTH-1:0] result_id_o;
    logic [4:0]            result_rd_o;
    logic [31:0]           result_data_o;

    logic [OW-1:0]         occupancy_o;

    modport master (
        output issue_valid_i, issue_id_i, issue_op_i, issue_bs_i,
        output issue_rd_i, issue_rs1_i, issue_rs2_i,
        output commit_valid_i, commit_id_i, commit_kill_i,
        output dp_rd_i, result_ready_i,
        input  issue_ready_o, dp_op_o, dp_bs_o, dp_rs1_o, dp_rs2_o,
        input  result_valid_o, result_id_o, result_rd_o, result_data_o,
        input  occupancy_o
    );

    modport slave (
        input  issue_valid_i, issue_id_i, issue_op_i, issue_bs_i,
        input  issue_rd_i, issue_rs1_i, issue_rs2_i,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        input  dp_rd_i, result_ready_i,
        output issue_ready_o, dp_op_o, dp_bs_o, dp_rs1_o, dp_rs2_o,
        output result_valid_o, result_id_o, result_rd_o, result_data_o,
        output occupancy_o
    );
endinterface

// File: rtl/aes_xif_scheduler.sv
// aes32 X-interface scheduler: in-order pending FIFO with commit/kill
// tracking feeding a shared datapath and a one-entry result register.
module aes_xif_scheduler #(
    parameter int X_ID_WIDTH = 4,
    parameter int DEPTH      = 2
) (
    input logic                clk_i,
    input logic                rst_i,
    aes_xif_scheduler_if.slave xif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [1:0]            op;
        logic [1:0]            bs;
        logic [4:0]            rd;
        logic [31:0]           rs1;
        logic [31:0]           rs2;
        logic                  cmt;
        logic                  kil;
    } entry_t;

    entry_t                q [DEPTH];
    logic [PW-1:0]         head_q;
    logic [PW-1:0]         tail_q;
    logic [CW-1:0]         count_q;

    logic                  res_valid_q;
    logic [X_ID_WIDTH-1:0] res_id_q;
    logic [4:0]            res_rd_q;
    logic [31:0]           res_data_q;

    logic                  not_empty;
    logic                  issue_fire;
    logic                  pop;
    logic                  pop_res;
    logic                  match_hit;
    logic [PW-1:0]         match_idx;
    logic [PW-1:0]         scan;
    entry_t                head_e;
    entry_t                new_e;

    assign not_empty  = count_q != '0;
    assign head_e     = q[head_q];
    assign issue_fire = xif.issue_valid_i & xif.issue_ready_o;

    // A killed head drops without touching the result register.
    assign pop     = not_empty & head_e.cmt &
                     (head_e.kil | ~res_valid_q | xif.result_ready_i);
    assign pop_res = pop & ~head_e.kil;

    always_comb begin
        new_e     = '0;
        new_e.id  = xif.issue_id_i;
        new_e.op  = xif.issue_op_i;
        new_e.bs  = xif.issue_bs_i;
        new_e.rd  = xif.issue_rd_i;
        new_e.rs1 = xif.issue_rs1_i;
        new_e.rs2 = xif.issue_rs2_i;
    end

    // Scan from the head so the oldest uncommitted id match wins.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        scan      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan = head_q + PW'(k);
            if (!match_hit && (CW'(k) < count_q) &&
                (q[scan].id == xif.commit_id_i) && !q[scan].cmt) begin
                match_hit = 1'b1;
                match_idx = scan;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_rd_q    <= '0;
            res_data_q  <= '0;
        end else begin
            if (issue_fire) begin
                q[tail_q] <= new_e;
                tail_q    <= tail_q + PW'(1);
            end
            if (xif.commit_valid_i && match_hit) begin
                q[match_idx].cmt <= 1'b1;
                q[match_idx].kil <= xif.commit_kill_i;
            end
            if (pop) head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(issue_fire) - CW'(pop);
            if (pop_res) begin
                res_valid_q <= 1'b1;
                res_id_q    <= head_e.id;
                res_rd_q    <= head_e.rd;
                res_data_q  <= xif.dp_rd_i;
            end else if (xif.result_ready_i) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign xif.issue_ready_o  = count_q < CW'(DEPTH);
    assign xif.occupancy_o    = count_q;

    assign xif.dp_op_o        = not_empty ? head_e.op  : '0;
    assign xif.dp_bs_o        = not_empty ? head_e.bs  : '0;
    assign xif.dp_rs1_o       = not_empty ? head_e.rs1 : '0;
    assign xif.dp_rs2_o       = not_empty ? head_e.rs2 : '0;

    assign xif.result_valid_o = res_valid_q;
    assign xif.result_id_o    = res_id_q;
    assign xif.result_rd_o    = res_rd_q;
    assign xif.result_data_o  = res_data_q;
endmodule
